tlatch_toggle_counter: RTL
==========================

# tlatch_toggle_counter

Downstream consumer of the T-latch output. It samples the latch's `Q` on a clock, detects every level change (toggle), and counts toggles over a fixed window of clock cycles. It then presents the count through a valid/ready handshake. Benches and higher-level blocks use it to check that `Q` toggled exactly as often as `T` pulses were applied while `En` was high.

## Interface
Parameters:
- `W`, 8, count width in bits; count saturates at 2^W-1.
- `WIN`, 16, window length in clock cycles; legal range WIN >= 1.

Ports:
- `clk`, input, 1, single clock, rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `Q`, input, 1, T-latch output; asynchronous to `clk`.
- `start`, input, 1, request a counting window; sampled only in IDLE, or on the cycle a report is accepted.
- `count`, output, W, toggle count of the last window.
- `count_valid`, output, 1, `count` and `ovf` are valid.
- `count_ready`, input, 1, consumer accepts the report.
- `ovf`, output, 1, count saturated during the window.
- `busy`, output, 1, high in COUNT and REPORT.

## Operation
- Sampling path:
  - `q_s` is `Q` through a sampling stage (see Configuration).
  - `q_prev` is `q_s` delayed one cycle and updates every cycle in every state.
  - `edge = q_s ^ q_prev`.
- FSM states are IDLE, COUNT and REPORT.
- IDLE:
  - `busy=0`, `count_valid=0`.
  - `start=1` → COUNT. On that transition: internal counter cleared to 0, internal overflow flag cleared, window timer loaded with WIN-1.
- COUNT:
  - Every cycle: if `edge`, counter += 1. If the counter is already 2^W-1, it holds and the internal overflow flag sets (sticky).
  - The timer decrements each cycle. On the cycle the timer = 0 (the last window cycle), that cycle's edge is still counted.
  - Next state is REPORT; the final counter value goes to `count` and the overflow flag goes to `ovf`.
  - `start` is ignored.
- REPORT:
  - `count_valid=1`; `count` and `ovf` are held stable until the handshake.
  - `count_valid & count_ready` → IDLE. If `start=1` in that same cycle, go straight to COUNT with the clear/load above.
  - `start` is ignored otherwise. Edges in REPORT are not counted.
- `count` and `ovf` keep their last reported values in IDLE and COUNT until the next report. They are qualified only by `count_valid`.

## Timing
- Reset (any state, including mid-window or mid-report): next cycle state=IDLE.
  - `count=0`, `count_valid=0`, `ovf=0`, `busy=0`.
  - Synchronizer flops and `q_prev` = 0; timer = 0; partial count discarded.
- A `Q` change sampled at edge n is counted at edge n+2 with the synchronizer and at edge n+1 without it.
- `start` high at edge k → `busy` high after edge k. Edges evaluated at edges k+1 … k+WIN are counted. `count_valid` rises after edge k+WIN.
- Report latency from `start` = WIN cycles. Back-to-back windows are possible with zero idle cycles via `start` during the accepting cycle.
- `count_valid` never drops without `count_ready`.
- After reset with `Q`=1, a spurious edge is possible until `q_prev` catches up (2 cycles with the synchronizer). The consumer waits ≥2 cycles after reset before `start`.

## Configuration
- Macro `TLATCH_TOGGLE_SYNC2_EN`:
  - Defined: `Q` passes through a 2-flop synchronizer before `q_s`; detection latency is as stated in Timing. Required whenever `Q` is truly asynchronous.
  - Undefined: a single register samples `Q` into `q_s`. Detection latency is one cycle less. `Q` must be generated synchronously to `clk`.

## Test plan
- Reset mid-COUNT with 3 toggles accumulated, `rst=1` for 1 cycle → `busy=0`, `count_valid=0`, `count=0`, `ovf=0`. A following window with no toggles reports `count=0`.
- WIN=16, W=8, `Q` toggled every 4 cycles, settled before the window and stable at its edges, `count_ready=1` → one report with `count=4`, `ovf=0`, `count_valid` high exactly 1 cycle, 16 cycles after `start`.
- `Q` held constant at 1 for a full window → `count=0`.
- W=2, `Q` toggled every cycle for WIN=16 → `count=3`, `ovf=1`. The next window, with 1 toggle, reports `count=1`, `ovf=0`.
- `count_ready=0` for 5 cycles during REPORT while `Q` toggles → `count_valid`, `count` and `ovf` stable all 5 cycles. Then `count_ready=1` with `start=1` → next cycle `busy=1`, `count_valid=0`, new window begins.
- Toggle placed on the last window cycle (edge k+WIN) → counted. Toggle one cycle later → not counted.
- Repeat all scenarios with and without `TLATCH_TOGGLE_SYNC2_EN`; check the 1-cycle detection-latency difference.

Source files
------------

// File: rtl/tlatch_toggle_counter.sv
// Counts Q level changes over a window of WIN clocks and reports the count over valid/ready.
// Define TLATCH_TOGGLE_SYNC2_EN to pass Q through a 2-flop synchronizer (asynchronous Q).
module tlatch_toggle_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned WIN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Q,
    input  logic         start,
    output logic [W-1:0] count,
    output logic         count_valid,
    input  logic         count_ready,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned    TW        = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [TW-1:0]  TimerLoad = TW'(WIN - 1);
    localparam logic [W-1:0]   CntMax    = '1;

    typedef enum logic [1:0] {StIdle, StCount, StReport} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          cnt_ovf_q, cnt_ovf_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          q_s;
    logic          q_prev_q;
    logic          q_edge;

`ifdef TLATCH_TOGGLE_SYNC2_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= Q;
            sync2_q <= sync1_q;
        end
    end

    assign q_s = sync2_q;
`else
    logic samp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= 1'b0;
        end else begin
            samp_q <= Q;
        end
    end

    assign q_s = samp_q;
`endif

    assign q_edge = q_s ^ q_prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_ovf_d = cnt_ovf_q;
        timer_d   = timer_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCount;
                    cnt_d     = '0;
                    cnt_ovf_d = 1'b0;
                    timer_d   = TimerLoad;
                end
            end
            StCount: begin
                if (q_edge) begin
                    if (cnt_q == CntMax) begin
                        cnt_ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                timer_d = timer_q - TW'(1);
                // Last window cycle: its own edge is already folded into cnt_d.
                if (timer_q == '0) begin
                    state_d = StReport;
                    count_d = cnt_d;
                    ovf_d   = cnt_ovf_d;
                    timer_d = '0;
                end
            end
            StReport: begin
                if (count_ready) begin
                    state_d = StIdle;
                    if (start) begin
                        state_d   = StCount;
                        cnt_d     = '0;
                        cnt_ovf_d = 1'b0;
                        timer_d   = TimerLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cnt_ovf_q <= 1'b0;
            timer_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            q_prev_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnt_ovf_q <= cnt_ovf_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            q_prev_q  <= q_s;
        end
    end

    assign busy        = (state_q != StIdle);
    assign count_valid = (state_q == StReport);
    assign count       = count_q;
    assign ovf         = ovf_q;

endmodule
